// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion engine.
package a2d_pkg;

    typedef enum logic [1:0] {IDLE, FRM1, GAP, FRM2} a2d_state_t;

    localparam int FRAME_BITS = 16;
    localparam int RES_BITS   = 12;

    // Divider start value: SCLK is high, and the first fall is a quarter period away.
    function automatic int div_preset(input int sclk_div);
        return sclk_div * 3 / 4 - 1;
    endfunction

    function automatic logic [FRAME_BITS-1:0] chnl_word(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_sclk_gen.sv
// SPI clock divider: SCLK is the divider MSB, with strobes on the clk that moves SCLK up or down.
// No latency beyond the divider register; load takes priority over enable.
module a2d_sclk_gen import a2d_pkg::*; #(
    parameter int SCLK_DIV = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int W = $clog2(SCLK_DIV);
    localparam logic [W-1:0] PRESET  = W'(div_preset(SCLK_DIV));
    localparam logic [W-1:0] HALF_M1 = W'(SCLK_DIV / 2 - 1);

    logic [W-1:0] div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= PRESET;
        end else if (load) begin
            div <= PRESET;
        end else if (en) begin
            div <= div + W'(1);
        end
    end

    // Strobes are unqualified; the caller gates them with its own frame state.
    assign sclk     = div[W-1];
    assign rise_stb = (div == HALF_M1);
    assign fall_stb = (div == '1);

endmodule

// File: rtl/a2d_cnv_engine.sv
// Two-frame SPI conversion responder: strt_cnv in, 12-bit res with cnv_cmplt out.
// Result 1074 clks after acceptance for SCLK_DIV=32; requests arriving while busy are dropped.
module a2d_cnv_engine import a2d_pkg::*; #(
    parameter int SCLK_DIV = 32,
    parameter int GAP_CYC  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                strt_cnv,
    input  logic [2:0]          chnnl,
    output logic                cnv_cmplt,
    output logic [RES_BITS-1:0] res,
    output logic                a2d_SS_n,
    output logic                SCLK,
    output logic                MOSI,
    input  logic                MISO
);

    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    a2d_state_t state, state_nxt;

    logic [2:0]            chan;
    logic [FRAME_BITS-1:0] tx;
    logic [RES_BITS-1:0]   rx;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;

    logic accept, frm_end, gap_end;
    logic in_frm, last_fall, div_en, div_load;
    logic rise_stb, fall_stb;

    assign in_frm    = (state == FRM1) || (state == FRM2);
    // The fall after the last rise never happens: the frame closes with SCLK held high.
    assign last_fall = in_frm && fall_stb && (bit_cnt == BW'(FRAME_BITS));
    assign div_en    = in_frm && !last_fall;
    assign div_load  = accept || gap_end;
    assign MOSI      = tx[FRAME_BITS-1];

    a2d_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (div_en),
        .load     (div_load),
        .sclk     (SCLK),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        frm_end   = 1'b0;
        gap_end   = 1'b0;
        case (state)
            IDLE: begin
                if (strt_cnv) begin
                    accept    = 1'b1;
                    state_nxt = FRM1;
                end
            end
            FRM1: begin
                if (last_fall) begin
                    frm_end   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    gap_end   = 1'b1;
                    state_nxt = FRM2;
                end
            end
            FRM2: begin
                if (last_fall) begin
                    frm_end   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan      <= '0;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            a2d_SS_n  <= 1'b1;
            cnv_cmplt <= 1'b0;
            res       <= '0;
        end else begin
            a2d_SS_n <= !((state_nxt == FRM1) || (state_nxt == FRM2));

            if (accept) begin
                chan      <= chnnl;
                cnv_cmplt <= 1'b0;
                tx        <= chnl_word(chnnl);
                bit_cnt   <= '0;
            end else if (gap_end) begin
                tx      <= chnl_word(chan);
                bit_cnt <= '0;
            end else if (in_frm) begin
                if (rise_stb) begin
                    rx      <= {rx[RES_BITS-2:0], MISO};
                    bit_cnt <= bit_cnt + BW'(1);
                end
                // MSB is already on MOSI for the first fall, so shifting starts at the second.
                if (fall_stb && !last_fall && (bit_cnt != '0)) begin
                    tx <= {tx[FRAME_BITS-2:0], 1'b0};
                end
            end

            if (frm_end) begin
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end

            if (frm_end && (state == FRM2)) begin
                res       <= rx;
                cnv_cmplt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_a2d_cnv_engine.sv
// Bench for a2d_cnv_engine: ADC model on the SPI pins plus frame timing and result checks.
module tb_a2d_cnv_engine;

    localparam int DIV        = 32;
    localparam int GAPC       = 32;
    localparam int FF_OFS     = DIV / 4 + 1;
    localparam int LOW_LEN    = FF_OFS + DIV / 2 + 15 * DIV + DIV / 2;
    localparam int CMPLT_LAT  = 2 * LOW_LEN + GAPC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        MISO = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        a2d_SS_n;
    logic        SCLK;
    logic        MOSI;

    a2d_cnv_engine #(
        .SCLK_DIV (DIV),
        .GAP_CYC  (GAPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .a2d_SS_n  (a2d_SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int e0 = 0;

    logic [11:0] adc_val [8];
    logic [3:0]  adc_up = 4'h0;

    // Per-frame observations
    int          low_q [$];
    int          rise_q [$];
    int          ff_q [$];
    int          gap_q [$];
    logic [15:0] mosi_q [$];

    // ADC model and frame monitor
    bit          in_frm = 0;
    bit          frm_par = 0;
    bit          cur_frm = 0;
    logic        p_ss = 1'b1;
    logic        p_sclk = 1'b1;
    int          fall_at = 0;
    int          last_rise = 0;
    int          rises = 0;
    int          falls = 0;
    int          ff = -1;
    logic [15:0] mosi_w = 16'h0;
    logic [15:0] miso_w = 16'h0;
    logic [2:0]  last_addr = 3'd0;

    always @(negedge clk) begin
        if (rst) begin
            in_frm  = 0;
            frm_par = 0;
            p_ss    = 1'b1;
            p_sclk  = 1'b1;
        end else begin
            if (p_ss && !a2d_SS_n) begin
                in_frm  = 1;
                fall_at = cyc;
                rises   = 0;
                falls   = 0;
                ff      = -1;
                mosi_w  = 16'h0;
                cur_frm = frm_par;
                frm_par = !frm_par;
                if (cur_frm) begin
                    gap_q.push_back(cyc - last_rise);
                    miso_w = {adc_up, adc_val[last_addr]};
                end else begin
                    miso_w = 16'($urandom);
                end
            end
            if (in_frm && p_sclk && !SCLK) begin
                if (falls == 0) ff = cyc - fall_at;
                if (falls < 16) MISO = miso_w[15 - falls];
                falls++;
            end
            if (in_frm && !p_sclk && SCLK) begin
                rises++;
                mosi_w = {mosi_w[14:0], MOSI};
            end
            if (in_frm && !p_ss && a2d_SS_n) begin
                in_frm = 0;
                low_q.push_back(cyc - fall_at);
                rise_q.push_back(rises);
                ff_q.push_back(ff);
                mosi_q.push_back(mosi_w);
                last_rise = cyc;
                if (!cur_frm) last_addr = mosi_w[13:11];
            end
            p_ss   = a2d_SS_n;
            p_sclk = SCLK;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller must be in the low phase of clk.
    task automatic start_conv(input logic [2:0] ch);
        low_q.delete();
        rise_q.delete();
        ff_q.delete();
        gap_q.delete();
        mosi_q.delete();
        strt_cnv = 1'b1;
        chnnl    = ch;
        @(posedge clk);
        #1;
        e0       = cyc;
        strt_cnv = 1'b0;
        chnnl    = 3'($urandom);
        check("accept_ss_n", a2d_SS_n, 1'b0);
        check("accept_cmplt", cnv_cmplt, 1'b0);
    endtask

    task automatic finish_conv(input logic [2:0] ch, input logic [11:0] exp_res, input bit busy);
        int t;
        bit got;
        logic [15:0] exp_word;
        t = 0;
        got = 0;
        exp_word = 16'(ch) << 11;
        for (int i = 0; i < CMPLT_LAT + 200 && !got; i++) begin
            @(negedge clk);
            if (busy && cyc == e0 + 299) begin
                strt_cnv = 1'b1;
                chnnl    = 3'd7;
            end else begin
                strt_cnv = 1'b0;
            end
            if (cnv_cmplt) begin
                got = 1;
                t   = cyc;
            end
        end
        strt_cnv = 1'b0;
        #1;
        check("cmplt_seen", got, 1'b1);
        check("cmplt_latency", t - e0, CMPLT_LAT);
        check("res", res, exp_res);
        check("n_frames", low_q.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (i < low_q.size()) begin
                check("ss_low_len", low_q[i], LOW_LEN);
                check("sclk_rises", rise_q[i], 16);
                check("first_fall", ff_q[i], FF_OFS);
                check("mosi_word", mosi_q[i], exp_word);
            end
        end
        check("gap_len", (gap_q.size() > 0) ? gap_q[0] : -1, GAPC);
    endtask

    logic [2:0]  sweep_ch [6];
    logic [2:0]  rch;
    logic [11:0] rval;

    initial begin
        sweep_ch = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
        for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ss_n", a2d_SS_n, 1'b1);
        check("rst_sclk", SCLK, 1'b1);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_cmplt", cnv_cmplt, 1'b0);
        check("rst_res", res, 12'h000);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single conversion
        adc_val[3] = 12'hA5C;
        adc_up     = 4'($urandom);
        start_conv(3'd3);
        finish_conv(3'd3, 12'hA5C, 0);

        // Busy request on channel 7 must be ignored
        adc_val[3] = 12'h5A1;
        adc_val[7] = 12'h3C3;
        start_conv(3'd3);
        finish_conv(3'd3, 12'h5A1, 1);
        low_q.delete();
        repeat (600) @(negedge clk);
        check("no_extra_frame", low_q.size(), 0);
        check("hold_res", res, 12'h5A1);
        check("hold_cmplt", cnv_cmplt, 1'b1);

        // Six-reading sweep, back to back
        for (int k = 0; k < 6; k++) begin
            adc_val[sweep_ch[k]] = 12'(k + 1);
            adc_up = 4'($urandom);
            start_conv(sweep_ch[k]);
            finish_conv(sweep_ch[k], 12'(k + 1), 0);
        end

        // Reset in the middle of frame 2
        start_conv(3'd5);
        repeat (701) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ss_n", a2d_SS_n, 1'b1);
        check("midrst_sclk", SCLK, 1'b1);
        check("midrst_mosi", MOSI, 1'b0);
        check("midrst_cmplt", cnv_cmplt, 1'b0);
        check("midrst_res", res, 12'h000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("postrst_cmplt", cnv_cmplt, 1'b0);
        check("postrst_ss_n", a2d_SS_n, 1'b1);
        adc_val[6] = 12'hFFF;
        start_conv(3'd6);
        finish_conv(3'd6, 12'hFFF, 0);

        // Boundary data with upper MISO bits forced high
        adc_up = 4'hF;
        adc_val[2] = 12'h000;
        start_conv(3'd2);
        finish_conv(3'd2, 12'h000, 0);
        adc_val[5] = 12'hFFF;
        start_conv(3'd5);
        finish_conv(3'd5, 12'hFFF, 0);

        // Random channels and values
        for (int k = 0; k < 4; k++) begin
            rch  = 3'($urandom);
            rval = 12'($urandom_range(0, 4095));
            adc_val[rch] = rval;
            adc_up = 4'($urandom);
            start_conv(rch);
            finish_conv(rch, rval, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
